water_flow_monitor: RTL



---
 rtl/water_flow_monitor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/water_flow_monitor.sv
// Fill/drain progress supervisor: windowed level sampling with stall counting.
// Optional WFM_OVERFLOW_DETECT_EN adds an immediate fill-overflow error.
module water_flow_monitor #(
   parameter int LEVEL_W        = 10,
   parameter int SAMPLE_DIV     = 1000,
   parameter int WINDOW_SAMPLES = 8,
   parameter int MIN_DELTA      = 4,
   parameter int STALL_LIMIT    = 3,
   parameter int OVERFLOW_LEVEL = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flow_reset,
   input  logic               flow_mode,
   input  logic [LEVEL_W-1:0] water_level_sensor,
   output logic               water_flow_error,
   output logic               monitor_active,
   output logic [3:0]         stall_count,
   output logic               overflow_flag
);

   localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CW = $clog2(WINDOW_SAMPLES + 1);
   localparam logic [PW-1:0]      PRE_LAST = PW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0]      WIN_LAST = CW'(WINDOW_SAMPLES);
   localparam logic [LEVEL_W-1:0] MIN_D    = LEVEL_W'(MIN_DELTA);
   localparam logic [LEVEL_W-1:0] OVF_LVL  = LEVEL_W'(OVERFLOW_LEVEL);
   localparam logic [3:0]         LIMIT    = 4'(STALL_LIMIT);
`ifdef WFM_OVERFLOW_DETECT_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MON, S_ERR} state_e;

   state_e             state_q;
   logic [PW-1:0]      pre_q, pre_d;
   logic [CW-1:0]      smp_q, smp_d;
   logic [LEVEL_W-1:0] base_q;
   logic               mode_q;
   logic [3:0]         stall_q, stall_d;
   logic               err_q, ovf_q, act_q;
   logic               tick, win_end, fill_ok, drain_ok, progress, over;
   logic [LEVEL_W-1:0] lvl;

   assign lvl      = water_level_sensor;
   assign tick     = (pre_q == PRE_LAST);
   assign pre_d    = tick ? '0 : pre_q + 1'b1;
   assign smp_d    = smp_q + 1'b1;
   assign win_end  = tick && (smp_d == WIN_LAST);
   assign stall_d  = stall_q + 4'd1;

   // Saturated sensor (fill) or empty tank (drain) cannot show more motion.
   assign fill_ok  = (lvl == '1) ||
                     ((lvl > base_q) && ((lvl - base_q) >= MIN_D));
   assign drain_ok = (lvl == '0) ||
                     ((lvl < base_q) && ((base_q - lvl) >= MIN_D));
   assign progress = mode_q ? fill_ok : drain_ok;
   assign over     = OVF_EN && mode_q && (lvl >= OVF_LVL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         smp_q   <= '0;
         base_q  <= '0;
         mode_q  <= 1'b0;
         stall_q <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         act_q   <= 1'b0;
      end else if (flow_reset) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         smp_q   <= '0;
         stall_q <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_ARM;
               act_q   <= 1'b1;
            end
            S_ARM: begin
               base_q  <= lvl;
               mode_q  <= flow_mode;
               pre_q   <= '0;
               smp_q   <= '0;
               state_q <= S_MON;
            end
            S_MON: begin
               if (flow_mode != mode_q) begin
                  state_q <= S_ARM;
                  stall_q <= '0;
               end else if (over) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
                  ovf_q   <= 1'b1;
                  act_q   <= 1'b0;
               end else begin
                  pre_q <= pre_d;
                  if (tick) smp_q <= smp_d;
                  if (win_end) begin
                     smp_q  <= '0;
                     base_q <= lvl;
                     if (progress) begin
                        stall_q <= '0;
                     end else begin
                        stall_q <= stall_d;
                        if (stall_d == LIMIT) begin
                           state_q <= S_ERR;
                           err_q   <= 1'b1;
                           act_q   <= 1'b0;
                        end
                     end
                  end
               end
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
         endcase
      end
   end

   assign water_flow_error = err_q;
   assign monitor_active   = act_q;
   assign stall_count      = stall_q;
   assign overflow_flag    = ovf_q;

endmodule
